// File: rtl/inst_mem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_loader_if
//  Description : Byte-stream input and instruction-memory write port bundle
//                for inst_mem_loader. The master modport is the loader side:
//                it accepts bytes and drives the memory write port. The slave
//                modport is the peer that sources bytes and owns the memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface inst_mem_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );
endinterface
`default_nettype wire

// File: rtl/inst_mem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : inst_mem_loader
//  Description : Fills the instruction memory from a big-endian byte stream
//                (4 bytes per 32-bit word, one write cycle per word), then
//                raises cpu_run so the processor may execute.
//                Optional feature macro: LOADER_CHECKSUM_EN - after the last
//                word one extra byte must equal the XOR of all program bytes,
//                otherwise the loader parks in an error state with err=1.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_mem_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  wire logic              clock,
    input  wire logic              reset_n,
    input  wire logic              start,
    input  wire logic [ADDR_W:0]   start_len,
    inst_mem_loader_if.master      bus,
    output logic                   cpu_run,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);

    localparam logic [ADDR_W:0] c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_one   = (ADDR_W+1)'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef LOADER_CHECKSUM_EN
        S_CHK   = 3'd4,
        S_ERR   = 3'd5,
`endif
        S_RUN   = 3'd3
    } state_t;

    // State entered once every word has been written (or immediately for len 0)
`ifdef LOADER_CHECKSUM_EN
    localparam state_t c_st_done = S_CHK;
`else
    localparam state_t c_st_done = S_RUN;
`endif

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   w_len_clamp;
    logic [ADDR_W-1:0] r_widx;
    logic [1:0]        r_bcnt;
    logic [23:0]       r_word;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_cpu_run;
    logic              r_busy;
    logic              r_done;
    logic              w_xfer;
    logic              w_last;
    logic              w_accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]        r_xor;
    logic              r_err;
`endif

    assign w_xfer = bus.in_valid & r_in_ready;
    assign w_last = ({1'b0, r_widx} == (r_len - c_one));

    // Requested length is clamped so the word address can never wrap
    always_comb begin
        w_len_clamp = (start_len > c_depth) ? c_depth : start_len;
    end

    // Start is honoured only while no load is in progress
    always_comb begin
        w_accept = 1'b0;
        if (start) begin
            case (r_state)
                S_IDLE, S_RUN: w_accept = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                S_ERR:         w_accept = 1'b1;
`endif
                default:       w_accept = 1'b0;
            endcase
        end
    end

    // Next-state selection
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (w_accept) begin
                    w_state_nxt = (w_len_clamp == '0) ? c_st_done : S_RECV;
                end
            end
            S_RECV: begin
                if (w_xfer && (r_bcnt == 2'd3)) begin
                    w_state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                w_state_nxt = w_last ? c_st_done : S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (w_xfer) begin
                    w_state_nxt = (bus.in_data == r_xor) ? S_RUN : S_ERR;
                end
            end
            S_ERR: begin
                if (w_accept) begin
                    w_state_nxt = (w_len_clamp == '0) ? c_st_done : S_RECV;
                end
            end
`endif
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, datapath and outputs registered from the next state
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_len       <= '0;
            r_widx      <= '0;
            r_bcnt      <= 2'd0;
            r_word      <= 24'd0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= 32'd0;
            r_cpu_run   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor       <= 8'd0;
            r_err       <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_mem_we  <= (w_state_nxt == S_WRITE);
            r_cpu_run <= (w_state_nxt == S_RUN);
            r_done    <= (w_state_nxt == S_RUN);
`ifdef LOADER_CHECKSUM_EN
            r_in_ready <= (w_state_nxt == S_RECV) || (w_state_nxt == S_CHK);
            r_busy     <= (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE) ||
                          (w_state_nxt == S_CHK);
            r_err      <= (w_state_nxt == S_ERR);
`else
            r_in_ready <= (w_state_nxt == S_RECV);
            r_busy     <= (w_state_nxt == S_RECV) || (w_state_nxt == S_WRITE);
`endif

            if (w_accept) begin
                r_len  <= w_len_clamp;
                r_widx <= '0;
                r_bcnt <= 2'd0;
`ifdef LOADER_CHECKSUM_EN
                r_xor  <= 8'd0;
`endif
            end

            // Bytes arrive most-significant first; the 4th completes the word
            if ((r_state == S_RECV) && w_xfer) begin
                r_word <= {r_word[15:0], bus.in_data};
                r_bcnt <= r_bcnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                r_xor  <= r_xor ^ bus.in_data;
`endif
                if (r_bcnt == 2'd3) begin
                    r_mem_addr  <= r_widx;
                    r_mem_wdata <= {r_word, bus.in_data};
                end
            end

            if (r_state == S_WRITE) begin
                r_widx <= r_widx + 1'b1;
            end
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign cpu_run       = r_cpu_run;
    assign busy          = r_busy;
    assign done          = r_done;
`ifdef LOADER_CHECKSUM_EN
    assign err           = r_err;
`else
    assign err           = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/inst_mem_loader.md
Name: inst_mem_loader

Overview:
- Upstream stage of single_cycle_mips: it fills the instruction memory (32-bit words, 10-bit word address) from a byte stream, then releases the processor to run.
- It takes over from file-based memory initialisation so the same program image can be loaded in-system.
- Sits between a byte source (host/UART bridge) and the inst_mem write port; drives a run-enable that gates processor clocking/PC update.

Parameters:
ADDR_W, 10, instruction memory word-address width (matches PC width).
DEPTH, 1024, number of instruction words; start_len clamped to DEPTH.

Ports:
clock  input  1  system clock, rising-edge.
reset_n  input  1  asynchronous active-low reset.
start  input  1  one-cycle pulse: begin load; sampled only in IDLE or RUN.
start_len  input  ADDR_W+1  number of 32-bit words to load, latched on accepted start.
in_valid  input  1  byte source has valid in_data.
in_data  input  8  program byte; big-endian, first byte of a word = bits [31:24].
in_ready  output  1  loader accepts byte this cycle; transfer = in_valid & in_ready.
mem_we  output  1  instruction memory write strobe, one cycle per word.
mem_addr  output  ADDR_W  word address for write.
mem_wdata  output  32  assembled instruction word.
cpu_run  output  1  processor may execute; 0 while loading.
busy  output  1  load in progress.
done  output  1  last load completed successfully.
err  output  1  load failed (checksum build only; else tied 0).

Behaviour:
- Reset (async, reset_n=0): state IDLE; in_ready, mem_we, cpu_run, busy, done, err = 0; mem_addr = 0; mem_wdata = 0; byte/word counters and len cleared. Memory contents are not touched. Partial words are discarded.
- FSM states are IDLE, RECV, WRITE, CHK (option only), RUN, ERR (option only).
- IDLE: start=1 latches len = min(start_len, DEPTH) and clears word index and byte count.
  - Next state is RECV; if len==0, next state is RUN with no writes.
- RECV: in_ready=1, decoded from registered state.
  - Each transfer shifts in_data into word register and increments byte count (0..3).
  - On the 4th byte, next state is WRITE, so in_ready=0 the following cycle.
  - Bytes presented while in_ready=0 must be held by the source; none are lost or duplicated.
- WRITE: mem_we=1 for exactly one cycle, with mem_addr = word index and mem_wdata = assembled word.
  - Then word index increments.
  - If word index was len-1, go to RUN (or CHK when option enabled); else go to RECV.
- Throughput: minimum 5 cycles per word (4 byte cycles + 1 write cycle).
- RUN: cpu_run=1, done=1, busy=0, in_ready=0.
  - start=1 restarts the load: cpu_run=0, done=0, busy=1 next cycle, state RECV (or RUN again if len==0).
- busy=1 in RECV, WRITE, CHK.
- start while busy is ignored.
- in_valid in IDLE/RUN/ERR is ignored (in_ready=0).
- Word address never exceeds DEPTH-1 (clamp guarantees no wrap).
- Output timing: mem_we/mem_addr/mem_wdata registered or decoded from registered state only; no combinational path from in_valid to mem_we.

Optional Feature:
LOADER_CHECKSUM_EN
- Defined: running XOR of all accepted program bytes.
  - After the last WRITE, state CHK with in_ready=1 accepts one extra byte.
  - If the byte equals the XOR, go to RUN.
  - Otherwise go to ERR: err=1, cpu_run=0, done=0, busy=0.
  - start from ERR restarts the load and clears err.
  - len==0 goes to CHK with expected XOR 0x00.
- Undefined: no CHK/ERR states; err tied 0; last WRITE goes directly to RUN.

Test Plan:
1. start_len=2, bytes 20 01 00 05 08 00 00 03 streamed back-to-back -> mem_we pulses at addr 0 data 0x20010005 and addr 1 data 0x08000003; cpu_run=1, done=1 the cycle after second write; exactly 2 mem_we pulses.
2. Same image with in_valid asserted every third cycle and held while in_ready=0 -> identical writes; in_ready=0 during each WRITE cycle; no byte dropped or repeated.
3. start_len=0 -> RUN one cycle after start; mem_we never asserted; done=1.
4. reset_n low for one cycle after 6 of 8 bytes -> all outputs 0 immediately; no further mem_we. A new start with len=1 and bytes AA BB CC DD -> addr 0 gets 0xAABBCCDD.
5. start pulsed mid-load -> ignored, load completes normally. Then start (len=1) in RUN -> cpu_run=0 next cycle, reload proceeds, cpu_run=1 again.
6. With LOADER_CHECKSUM_EN, len=1, bytes 12 34 56 78:
   - checksum byte 0x08 -> RUN, err=0.
   - checksum byte 0x09 -> err=1, cpu_run=0, done=0.
